// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter and pending-write scoreboard for the 32x32 register file.
// Define RF_BYPASS_EN to add same-cycle forwarding of the registered write-back.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_READY,
    output logic               RFWE,
    output logic [AW-1:0]      RFWA,
    output logic [DW-1:0]      RFWD,
    input  logic               ISSUE_EN,
    input  logic [AW-1:0]      ISSUE_ADDR,
    output logic               ISSUE_STALL,
    input  logic [AW-1:0]      RD_ADDR1,
    input  logic [AW-1:0]      RD_ADDR2,
    output logic               HAZARD,
`ifdef RF_BYPASS_EN
    output logic               FWD_HIT1,
    output logic               FWD_HIT2,
    output logic [DW-1:0]      FWD_DATA1,
    output logic [DW-1:0]      FWD_DATA2,
`endif
    output logic [(1<<AW)-1:0] BUSY
);

    localparam int NR = 1 << AW;
    localparam int LW = (NREQ > 2) ? 2 : 1;

    logic [LW-1:0] last;
    logic [LW-1:0] idx;
    logic [LW-1:0] gidx;
    logic          found;
    logic [NREQ-1:0] grant;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;
    logic [NR-1:0] busy;
    logic [NR-1:0] busy_nxt;
    logic          h1;
    logic          h2;
    logic          f1;
    logic          f2;

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        grant = '0;
        gidx  = last;
        idx   = last;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == LW'(NREQ - 1)) ? '0 : idx + LW'(1);
            if (!found && REQ_VALID[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    assign REQ_READY = grant;

    always_comb begin
        gaddr = '0;
        gdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                gaddr = REQ_ADDR[j*AW +: AW];
                gdata = REQ_DATA[j*DW +: DW];
            end
        end
    end

    assign ISSUE_STALL = busy[ISSUE_ADDR] & (ISSUE_ADDR != '0);

    // Set is applied after clear so a same-edge reissue wins.
    always_comb begin
        busy_nxt = busy;
        if (RFWE) busy_nxt[RFWA] = 1'b0;
        if (ISSUE_EN && !ISSUE_STALL) busy_nxt[ISSUE_ADDR] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RFWE <= 1'b0;
            RFWA <= '0;
            RFWD <= '0;
            last <= LW'(NREQ - 1);
            busy <= '0;
        end else begin
            RFWE <= found && (gaddr != '0);
            if (found) begin
                RFWA <= gaddr;
                RFWD <= gdata;
                last <= gidx;
            end
            busy <= busy_nxt;
        end
    end

    assign BUSY = busy;
    assign h1 = (RD_ADDR1 != '0) & busy[RD_ADDR1];
    assign h2 = (RD_ADDR2 != '0) & busy[RD_ADDR2];

`ifdef RF_BYPASS_EN
    assign f1 = RFWE & (RFWA == RD_ADDR1) & (RD_ADDR1 != '0);
    assign f2 = RFWE & (RFWA == RD_ADDR2) & (RD_ADDR2 != '0);
    assign FWD_HIT1  = f1;
    assign FWD_HIT2  = f2;
    assign FWD_DATA1 = RFWD;
    assign FWD_DATA2 = RFWD;
`else
    assign f1 = 1'b0;
    assign f2 = 1'b0;
`endif

    assign HAZARD = (h1 & ~f1) | (h2 & ~f2);

endmodule
